// File: rtl/riscv_multicycle_if.sv
// Unified instruction/data memory port of the multicycle core.
// The core is the master; mem_rdata/mem_ready return from the memory.
interface riscv_multicycle_if #(
  parameter int unsigned N = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core (lw/sw/add/sub/and/or/slt/addi/andi/ori/slti/beq/jal)
// sharing one memory port between instruction fetch and data access.
module riscv_multicycle #(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  riscv_multicycle_if.master  mem_bus,
  output logic                retire,
  output logic                trap,
  output logic [N-1:0]        pc_out
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t       r_state, w_next, w_dec_next;
  logic [N-1:0] r_pc, r_oldpc, r_a, r_b, r_aluout, r_data;
  logic [31:0]  r_ir;
  logic [N-1:0] r_rf [32];

  logic [6:0]   w_opcode, w_funct7;
  logic [2:0]   w_funct3;
  logic [4:0]   w_rd, w_rs1, w_rs2;
  logic [N-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
  logic [N-1:0] w_op2, w_alu, w_rf_wdata;
  logic         w_rf_we;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_funct3 = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_funct7 = r_ir[31:25];

  assign w_imm_i = {{(N-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(N-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(N-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_j = {{(N-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  assign pc_out = r_pc;

  // R-type and I-type share the ALU; only R-type with funct7[5] subtracts
  always_comb begin
    w_op2 = (r_state == EXEC_R) ? r_b : w_imm_i;
    w_alu = '0;
    case (w_funct3)
      3'b000:  w_alu = (r_state == EXEC_R && w_funct7[5]) ? r_a - w_op2 : r_a + w_op2;
      3'b111:  w_alu = r_a & w_op2;
      3'b110:  w_alu = r_a | w_op2;
      3'b010:  w_alu = {{(N-1){1'b0}}, ($signed(r_a) < $signed(w_op2))};
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_dec_next = TRAP;
    case (w_opcode)
      OP_LOAD, OP_STORE:
        if (w_funct3 == 3'b010) w_dec_next = MEMADR;
      OP_R:
        if ((w_funct7 == 7'b0000000 && (w_funct3 inside {3'b000, 3'b111, 3'b110, 3'b010})) ||
            (w_funct7 == 7'b0100000 && w_funct3 == 3'b000))
          w_dec_next = EXEC_R;
      OP_IMM:
        if (w_funct3 inside {3'b000, 3'b111, 3'b110, 3'b010}) w_dec_next = EXEC_I;
      OP_BRANCH:
        if (w_funct3 == 3'b000) w_dec_next = BRANCH;
      OP_JAL:  w_dec_next = JAL;
      default: w_dec_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    mem_bus.mem_req   = 1'b0;
    mem_bus.mem_we    = 1'b0;
    mem_bus.mem_addr  = r_pc;
    mem_bus.mem_wdata = r_b;
    retire            = 1'b0;
    trap              = 1'b0;
    w_rf_we           = 1'b0;
    w_rf_wdata        = r_aluout;
    case (r_state)
      FETCH: begin
        mem_bus.mem_req = 1'b1;
        if (mem_bus.mem_ready) w_next = DECODE;
      end
      DECODE: w_next = w_dec_next;
      MEMADR: w_next = w_opcode[5] ? MEMWR : MEMRD;
      MEMRD: begin
        mem_bus.mem_req  = 1'b1;
        mem_bus.mem_addr = r_aluout;
        if (mem_bus.mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        retire     = 1'b1;
        w_rf_we    = 1'b1;
        w_rf_wdata = r_data;
        w_next     = FETCH;
      end
      MEMWR: begin
        mem_bus.mem_req  = 1'b1;
        mem_bus.mem_we   = 1'b1;
        mem_bus.mem_addr = r_aluout;
        if (mem_bus.mem_ready) begin
          retire = 1'b1;
          w_next = FETCH;
        end
      end
      EXEC_R, EXEC_I: w_next = ALUWB;
      ALUWB: begin
        retire  = 1'b1;
        w_rf_we = 1'b1;
        w_next  = FETCH;
      end
      BRANCH: begin
        retire = 1'b1;
        w_next = FETCH;
      end
      JAL: begin
        retire     = 1'b1;
        w_rf_we    = 1'b1;
        w_rf_wdata = r_oldpc + N'(4);
        w_next     = FETCH;
      end
      TRAP: trap = 1'b1;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_data   <= '0;
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        FETCH:
          if (mem_bus.mem_ready) begin
            r_ir    <= mem_bus.mem_rdata[31:0];
            r_oldpc <= r_pc;
            r_pc    <= r_pc + N'(4);
          end
        DECODE: begin
          r_a      <= r_rf[w_rs1];
          r_b      <= r_rf[w_rs2];
          r_aluout <= r_oldpc + w_imm_b;
        end
        MEMADR:         r_aluout <= r_a + (w_opcode[5] ? w_imm_s : w_imm_i);
        MEMRD:          if (mem_bus.mem_ready) r_data <= mem_bus.mem_rdata;
        EXEC_R, EXEC_I: r_aluout <= w_alu;
        BRANCH:         if (r_a == r_b) r_pc <= r_aluout;
        JAL:            r_pc <= r_oldpc + w_imm_j;
        default: ;
      endcase
      if (w_rf_we && w_rd != 5'd0) r_rf[w_rd] <= w_rf_wdata;
    end
  end
endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed bench for riscv_multicycle: table of ALU vectors observed through
// stores, plus hand-written sequences for waits, branches, jal, trap and reset.
module tb_riscv_multicycle;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        retire, trap;
  logic [31:0] pc_out;

  riscv_multicycle_if #(.N(32)) bus ();

  riscv_multicycle #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus),
    .retire  (retire),
    .trap    (trap),
    .pc_out  (pc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rd_addr[$], wr_addr[$], wr_data[$], ret_cyc[$];
  int          stall_cfg  = 0;
  bit          stall_once = 1'b0;
  int          wcnt       = 0;
  int          cyc        = 0;

  // memory responder: decides ready on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end else if (bus.mem_req) begin
      if (wcnt < stall_cfg) begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end else begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr[9:2]];
        wcnt = 0;
        if (stall_once) stall_cfg = 0;
      end
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst) cyc = 0;
    else begin
      cyc++;
      if (retire) ret_cyc.push_back(cyc);
      if (bus.mem_req && bus.mem_ready) begin
        if (bus.mem_we) begin
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
          mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        end else rd_addr.push_back(bus.mem_addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rd_addr.delete(); wr_addr.delete(); wr_data.delete(); ret_cyc.delete();
    stall_cfg  = 0;
    stall_once = 1'b0;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_to_trap(input int limit, input string nm);
    int n = 0;
    while (!trap && n < limit) begin
      tick();
      n++;
    end
    chk({nm, "_trap"}, {31'b0, trap}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [12];

  initial begin
    int nret;
    int found;
    // x5=a, x6=b, result to x4
    vt[0]  = '{32'd7,         32'd5,         enc_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd4), 32'd12};
    vt[1]  = '{32'd5,         32'd7,         enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd4), 32'hFFFF_FFFE};
    vt[2]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, enc_r(7'h00, 5'd6, 5'd5, 3'b111, 5'd4), 32'h00F0_00F0};
    vt[3]  = '{32'hF0F0_0000, 32'h0000_0F0F, enc_r(7'h00, 5'd6, 5'd5, 3'b110, 5'd4), 32'hF0F0_0F0F};
    vt[4]  = '{32'hFFFF_FFFF, 32'd1,         enc_r(7'h00, 5'd6, 5'd5, 3'b010, 5'd4), 32'd1};
    vt[5]  = '{32'd1,         32'hFFFF_FFFF, enc_r(7'h00, 5'd6, 5'd5, 3'b010, 5'd4), 32'd0};
    vt[6]  = '{32'd0,         32'd0,         enc_i(12'hFFF, 5'd5, 3'b000, 5'd4, OP_I), 32'hFFFF_FFFF};
    vt[7]  = '{32'h1234_5678, 32'd0,         enc_i(12'h0FF, 5'd5, 3'b111, 5'd4, OP_I), 32'h0000_0078};
    vt[8]  = '{32'h0000_0012, 32'd0,         enc_i(12'h800, 5'd5, 3'b110, 5'd4, OP_I), 32'hFFFF_F812};
    vt[9]  = '{32'h8000_0000, 32'd0,         enc_i(12'hFFF, 5'd5, 3'b010, 5'd4, OP_I), 32'd1};
    vt[10] = '{32'hFFFF_FFFF, 32'd2,         enc_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd4), 32'd1};
    vt[11] = '{32'd9,         32'd1,         enc_r(7'h20, 5'd6, 5'd0, 3'b000, 5'd4), 32'hFFFF_FFFF};

    begin_reset();
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_trap",   {31'b0, trap},   32'd0);
    chk("rst_pc",     pc_out,          32'h0);
    chk("rst_req",    {31'b0, bus.mem_req}, 32'd1);
    chk("rst_addr",   bus.mem_addr,    32'h0);

    for (int i = 0; i < 12; i++) begin
      begin_reset();
      mem[0]  = enc_i(12'h100, 5'd0, 3'b010, 5'd5, OP_LD);
      mem[1]  = enc_i(12'h104, 5'd0, 3'b010, 5'd6, OP_LD);
      mem[2]  = vt[i].instr;
      mem[3]  = enc_s(12'h108, 5'd4, 5'd0);
      mem[64] = vt[i].a;
      mem[65] = vt[i].b;
      release_rst();
      run_to_trap(80, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_wdata", i), qget(wr_data, 0), vt[i].exp);
      chk($sformatf("vec%0d_waddr", i), qget(wr_addr, 0), 32'h108);
      chk($sformatf("vec%0d_retcyc", i), qget(ret_cyc, 3), 32'd18);
    end

    // fetch with three wait cycles
    begin_reset();
    mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_s(12'h100, 5'd1, 5'd0);
    stall_cfg  = 3;
    stall_once = 1'b1;
    release_rst();
    nret = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 3) begin
        chk($sformatf("wait_addr%0d", k), bus.mem_addr, 32'h0);
        chk($sformatf("wait_req%0d", k), {31'b0, bus.mem_req}, 32'd1);
      end
      if (retire) nret++;
      if (k == 7) chk("wait_retire_c7", {31'b0, retire}, 32'd1);
    end
    chk("wait_nretire", nret, 32'd1);
    run_to_trap(40, "wait");
    chk("wait_x1", qget(wr_data, 0), 32'd5);

    // store then load through the same address
    begin_reset();
    mem[0] = enc_i(12'h040, 5'd0, 3'b000, 5'd2, OP_I);
    mem[1] = enc_s(12'h000, 5'd2, 5'd2);
    mem[2] = enc_i(12'h000, 5'd2, 3'b010, 5'd3, OP_LD);
    mem[3] = enc_s(12'h004, 5'd3, 5'd2);
    release_rst();
    run_to_trap(60, "ldst");
    chk("ldst_waddr0", qget(wr_addr, 0), 32'h40);
    chk("ldst_wdata0", qget(wr_data, 0), 32'h40);
    chk("ldst_x3",     qget(wr_data, 1), 32'h40);
    chk("ldst_ret2",   qget(ret_cyc, 1), 32'd8);
    chk("ldst_ret3",   qget(ret_cyc, 2), 32'd13);

    // taken branch at 0x10
    begin_reset();
    mem[0] = enc_j(21'd16, 5'd0);
    mem[4] = enc_b(13'd8, 5'd0, 5'd0);
    release_rst();
    run_to_trap(40, "beqt");
    chk("beqt_f1",   qget(rd_addr, 1), 32'h10);
    chk("beqt_f2",   qget(rd_addr, 2), 32'h18);
    chk("beqt_ret1", qget(ret_cyc, 1), 32'd6);
    chk("beqt_pc",   pc_out, 32'h1C);

    // not-taken branch at 0x10
    begin_reset();
    mem[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_i(12'd2, 5'd0, 3'b000, 5'd2, OP_I);
    mem[2] = enc_j(21'd8, 5'd0);
    mem[4] = enc_b(13'd8, 5'd2, 5'd1);
    release_rst();
    run_to_trap(60, "beqn");
    chk("beqn_f4", qget(rd_addr, 4), 32'h14);

    // backward jal with link, then write to x0
    begin_reset();
    mem[0] = enc_j(21'd32, 5'd0);
    mem[8] = enc_j(21'h1F_FFF0, 5'd1);
    mem[4] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_I);
    mem[5] = enc_s(12'h100, 5'd1, 5'd0);
    mem[6] = enc_s(12'h104, 5'd0, 5'd0);
    release_rst();
    run_to_trap(60, "jal");
    chk("jal_f2",   qget(rd_addr, 2), 32'h10);
    chk("jal_link", qget(wr_data, 0), 32'h24);
    chk("jal_x0",   qget(wr_data, 1), 32'h0);

    // illegal opcode, then reset recovery
    begin_reset();
    release_rst();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) chk("ill_req_c1", {31'b0, bus.mem_req}, 32'd1);
      if (k == 2) chk("ill_trap_c2", {31'b0, trap}, 32'd0);
      if (k >= 3) begin
        chk($sformatf("ill_trap_c%0d", k), {31'b0, trap}, 32'd1);
        chk($sformatf("ill_req_c%0d", k), {31'b0, bus.mem_req}, 32'd0);
      end
    end
    rst = 1'b0;
    #1;
    chk("ill_rst_trap", {31'b0, trap}, 32'd0);
    chk("ill_rst_pc",   pc_out, 32'h0);
    release_rst();
    tick();
    chk("ill_refetch_req",  {31'b0, bus.mem_req}, 32'd1);
    chk("ill_refetch_addr", bus.mem_addr, 32'h0);

    // reset during a stalled store abandons it
    begin_reset();
    mem[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd1, OP_I);
    mem[1] = enc_s(12'h100, 5'd1, 5'd0);
    stall_cfg = 4;
    release_rst();
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      tick();
      if (bus.mem_req && bus.mem_we) found = 1;
    end
    chk("abort_reach_memwr", found, 32'd1);
    chk("abort_hold_addr", bus.mem_addr, 32'h100);
    tick();
    chk("abort_hold_we", {31'b0, bus.mem_we}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_we_low", {31'b0, bus.mem_we}, 32'd0);
    chk("abort_nowrite", wr_data.size(), 32'd0);
    rd_addr.delete();
    release_rst();
    run_to_trap(120, "abort");
    chk("abort_refetch", qget(rd_addr, 0), 32'h0);
    chk("abort_nwrites", wr_data.size(), 32'd1);
    chk("abort_wdata",   qget(wr_data, 0), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
